// File: rtl/int_calc_seq.sv
// Multi-cycle unsigned integer calculator: add/sub in one step, shared shift-add multiplier, restoring divider.
// Define INT_CALC_POW_EN to build the iterative square-and-multiply power operation (opcode 101).
module int_calc_seq #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_REM = 3'b100;
   localparam logic [2:0] OP_POW = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ALU     = 3'd1,
      MUL     = 3'd2,
      DIV     = 3'd3,
`ifdef INT_CALC_POW_EN
      POW_MUL = 3'd4,
      POW_SQR = 3'd5,
`endif
      DONE    = 3'd6
   } state_t;

   state_t           state_r, state_n;
   logic [2:0]       op_r, op_n;
   logic [WIDTH-1:0] a_r, a_n, b_r, b_n;
   logic             first_r, first_n;
   logic [CW-1:0]    cnt_r, cnt_n;
   logic [WIDTH-1:0] ph_r, ph_n, pl_r, pl_n;
   logic [WIDTH-1:0] rem_r, rem_n, quo_r, quo_n;
   logic [WIDTH-1:0] res_r, res_n;
   logic             res_err_r, res_err_n;
   logic             busy_r, busy_n, done_r, done_n, err_r, err_n;
   logic [WIDTH-1:0] out_r, out_n;
`ifdef INT_CALC_POW_EN
   logic [WIDTH-1:0] acc_r, acc_n, base_r, base_n, exp_r, exp_n;
`endif

   logic [WIDTH-1:0] mul_x_s, mul_y_s, mul_add_s, mul_prod_s;
   logic [WIDTH:0]   mul_sum_s, rem_sh_s, div_diff_s;
   logic [WIDTH-1:0] div_rem_s, div_quo_s;
   logic             last_s;

   // Multiplier operand routing: the power states share the MUL engine.
   always_comb begin
      mul_x_s = a_r;
      mul_y_s = b_r;
`ifdef INT_CALC_POW_EN
      if (state_r == POW_MUL) begin
         mul_x_s = acc_r;
         mul_y_s = base_r;
      end else if (state_r == POW_SQR) begin
         mul_x_s = base_r;
         mul_y_s = base_r;
      end else begin
         mul_x_s = a_r;
         mul_y_s = b_r;
      end
`endif
   end

   // Product {ph,pl} shifts right each step; the carry of the upper add lands in ph's MSB.
   assign mul_add_s  = mul_y_s[cnt_r] ? mul_x_s : '0;
   assign mul_sum_s  = {1'b0, ph_r} + {1'b0, mul_add_s};
   assign mul_prod_s = {mul_sum_s[0], pl_r[WIDTH-1:1]};
   assign rem_sh_s   = {rem_r, quo_r[WIDTH-1]};
   assign div_diff_s = rem_sh_s - {1'b0, b_r};
   assign div_rem_s  = div_diff_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
   assign div_quo_s  = {quo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
   assign last_s     = (cnt_r == CW'(WIDTH - 1));

   // Next-state and datapath update; the first cycle of each iterative op stages its working registers.
   always_comb begin
      state_n   = state_r;
      op_n      = op_r;
      a_n       = a_r;
      b_n       = b_r;
      first_n   = first_r;
      cnt_n     = cnt_r;
      ph_n      = ph_r;
      pl_n      = pl_r;
      rem_n     = rem_r;
      quo_n     = quo_r;
      res_n     = res_r;
      res_err_n = res_err_r;
      busy_n    = busy_r;
      done_n    = 1'b0;
      out_n     = out_r;
      err_n     = err_r;
`ifdef INT_CALC_POW_EN
      acc_n     = acc_r;
      base_n    = base_r;
      exp_n     = exp_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               op_n    = operation;
               a_n     = opa;
               b_n     = opb;
               first_n = 1'b1;
               busy_n  = 1'b1;
               case (operation)
                  OP_MUL:         state_n = MUL;
                  OP_DIV, OP_REM: state_n = (opb == '0) ? ALU : DIV;
`ifdef INT_CALC_POW_EN
                  OP_POW:         state_n = (opb == '0) ? ALU : POW_MUL;
`endif
                  default:        state_n = ALU;
               endcase
            end else begin
               state_n = IDLE;
            end
         end
         ALU: begin
            case (op_r)
               OP_ADD:  begin res_n = a_r + b_r;        res_err_n = 1'b0; end
               OP_SUB:  begin res_n = a_r - b_r;        res_err_n = 1'b0; end
               OP_DIV:  begin res_n = {WIDTH{1'b1}};    res_err_n = 1'b1; end
               OP_REM:  begin res_n = a_r;              res_err_n = 1'b1; end
`ifdef INT_CALC_POW_EN
               OP_POW:  begin res_n = WIDTH'(1);        res_err_n = 1'b0; end
`endif
               default: begin res_n = '0;               res_err_n = 1'b1; end
            endcase
            state_n = DONE;
         end
         MUL: begin
            if (first_r) begin
               first_n = 1'b0;
               ph_n    = '0;
               pl_n    = '0;
               cnt_n   = '0;
            end else if (last_s) begin
               res_n     = mul_prod_s;
               res_err_n = 1'b0;
               state_n   = DONE;
            end else begin
               ph_n  = mul_sum_s[WIDTH:1];
               pl_n  = mul_prod_s;
               cnt_n = cnt_r + 1'b1;
            end
         end
         DIV: begin
            if (first_r) begin
               first_n = 1'b0;
               rem_n   = '0;
               quo_n   = a_r;
               cnt_n   = '0;
            end else if (last_s) begin
               res_n     = (op_r == OP_DIV) ? div_quo_s : div_rem_s;
               res_err_n = 1'b0;
               state_n   = DONE;
            end else begin
               rem_n = div_rem_s;
               quo_n = div_quo_s;
               cnt_n = cnt_r + 1'b1;
            end
         end
`ifdef INT_CALC_POW_EN
         POW_MUL: begin
            if (first_r) begin
               first_n = 1'b0;
               acc_n   = WIDTH'(1);
               base_n  = a_r;
               exp_n   = b_r;
               ph_n    = '0;
               pl_n    = '0;
               cnt_n   = '0;
               state_n = b_r[0] ? POW_MUL : POW_SQR;
            end else if (last_s) begin
               acc_n   = mul_prod_s;
               ph_n    = '0;
               pl_n    = '0;
               cnt_n   = '0;
               state_n = POW_SQR;
            end else begin
               ph_n  = mul_sum_s[WIDTH:1];
               pl_n  = mul_prod_s;
               cnt_n = cnt_r + 1'b1;
            end
         end
         POW_SQR: begin
            if (last_s) begin
               base_n = mul_prod_s;
               exp_n  = exp_r >> 1;
               ph_n   = '0;
               pl_n   = '0;
               cnt_n  = '0;
               if ((exp_r >> 1) == '0) begin
                  res_n     = acc_r;
                  res_err_n = 1'b0;
                  state_n   = DONE;
               end else begin
                  state_n = exp_r[1] ? POW_MUL : POW_SQR;
               end
            end else begin
               ph_n  = mul_sum_s[WIDTH:1];
               pl_n  = mul_prod_s;
               cnt_n = cnt_r + 1'b1;
            end
         end
`endif
         DONE: begin
            out_n   = res_r;
            err_n   = res_err_r;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         op_r      <= 3'b000;
         a_r       <= '0;
         b_r       <= '0;
         first_r   <= 1'b0;
         cnt_r     <= '0;
         ph_r      <= '0;
         pl_r      <= '0;
         rem_r     <= '0;
         quo_r     <= '0;
         res_r     <= '0;
         res_err_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         out_r     <= '0;
         err_r     <= 1'b0;
`ifdef INT_CALC_POW_EN
         acc_r     <= '0;
         base_r    <= '0;
         exp_r     <= '0;
`endif
      end else begin
         state_r   <= state_n;
         op_r      <= op_n;
         a_r       <= a_n;
         b_r       <= b_n;
         first_r   <= first_n;
         cnt_r     <= cnt_n;
         ph_r      <= ph_n;
         pl_r      <= pl_n;
         rem_r     <= rem_n;
         quo_r     <= quo_n;
         res_r     <= res_n;
         res_err_r <= res_err_n;
         busy_r    <= busy_n;
         done_r    <= done_n;
         out_r     <= out_n;
         err_r     <= err_n;
`ifdef INT_CALC_POW_EN
         acc_r     <= acc_n;
         base_r    <= base_n;
         exp_r     <= exp_n;
`endif
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign out  = out_r;
   assign err  = err_r;

endmodule

// File: tb/tb_int_calc_seq.sv
// Directed, table-driven bench for int_calc_seq: three instances (WIDTH 64, 8, 16) share clock, reset and stimulus.
module tb_int_calc_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_c = 1'b0;
   logic [2:0]  op_c = 3'b000;
   logic [63:0] a_c = 64'd0;
   logic [63:0] b_c = 64'd0;
   int          sel = 0;

   logic        start64, start8, start16;
   logic        busy64, busy8, busy16, done64, done8, done16, err64, err8, err16;
   logic [63:0] out64;
   logic [7:0]  out8;
   logic [15:0] out16;
   logic        busy_m, done_m, err_m;
   logic [63:0] out_m;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          sel;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp_out;
      logic        exp_err;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   assign start64 = start_c && (sel == 0);
   assign start8  = start_c && (sel == 1);
   assign start16 = start_c && (sel == 2);

   always_comb begin
      busy_m = busy64; done_m = done64; err_m = err64; out_m = out64;
      if (sel == 1) begin
         busy_m = busy8; done_m = done8; err_m = err8; out_m = {56'd0, out8};
      end else if (sel == 2) begin
         busy_m = busy16; done_m = done16; err_m = err16; out_m = {48'd0, out16};
      end
   end

   int_calc_seq #(.WIDTH(64)) d64 (.clk(clk), .rst(rst), .start(start64), .operation(op_c),
      .opa(a_c), .opb(b_c), .busy(busy64), .done(done64), .out(out64), .err(err64));
   int_calc_seq #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .start(start8), .operation(op_c),
      .opa(a_c[7:0]), .opb(b_c[7:0]), .busy(busy8), .done(done8), .out(out8), .err(err8));
   int_calc_seq #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .start(start16), .operation(op_c),
      .opa(a_c[15:0]), .opb(b_c[15:0]), .busy(busy16), .done(done16), .out(out16), .err(err16));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one request; returns one ns after the accepting edge with start already dropped.
   task automatic start_op(input int s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      sel = s; op_c = op; a_c = a; b_c = b; start_c = 1'b1;
      @(posedge clk);
      #1 start_c = 1'b0;
   endtask

   // Counts edges until done is seen; a budget overrun returns the budget value.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (cyc < 300) begin
         @(posedge clk);
         #1 cyc++;
         if (done_m) break;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      start_op(v.sel, v.op, v.a, v.b);
      wait_done(cyc);
      check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
      check({v.name, " out"}, out_m, v.exp_out);
      check({v.name, " err"}, {63'd0, err_m}, {63'd0, v.exp_err});
   endtask

   initial begin
      int c1, c2, pulses;

      vecs.push_back('{0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 2, "add64 wrap"});
      vecs.push_back('{0, 3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2, "sub64 borrow"});
      vecs.push_back('{0, 3'b011, 64'd1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, "div64 by zero"});
      vecs.push_back('{0, 3'b100, 64'd1000, 64'd0, 64'd1000, 1'b1, 2, "rem64 by zero"});
      vecs.push_back('{0, 3'b010, 64'd123456789, 64'd1000, 64'd123456789000, 1'b0, 66, "mul64"});
      vecs.push_back('{1, 3'b010, 64'd255, 64'd255, 64'd1, 1'b0, 10, "mul8 255x255"});
      vecs.push_back('{1, 3'b011, 64'd200, 64'd7, 64'd28, 1'b0, 10, "div8"});
      vecs.push_back('{1, 3'b100, 64'd200, 64'd7, 64'd4, 1'b0, 10, "rem8"});
      vecs.push_back('{1, 3'b111, 64'd9, 64'd4, 64'd0, 1'b1, 2, "illegal 111"});
      vecs.push_back('{1, 3'b110, 64'd9, 64'd4, 64'd0, 1'b1, 2, "illegal 110"});
`ifdef INT_CALC_POW_EN
      vecs.push_back('{1, 3'b101, 64'd3, 64'd5, 64'd243, 1'b0, 42, "pow 3^5"});
      vecs.push_back('{1, 3'b101, 64'd2, 64'd9, 64'd0, 1'b0, 50, "pow 2^9"});
      vecs.push_back('{1, 3'b101, 64'd0, 64'd0, 64'd1, 1'b0, 2, "pow 0^0"});
      vecs.push_back('{1, 3'b101, 64'd7, 64'd1, 64'd7, 1'b0, 18, "pow 7^1"});
`else
      vecs.push_back('{1, 3'b101, 64'd3, 64'd5, 64'd0, 1'b1, 2, "pow 3^5 disabled"});
      vecs.push_back('{1, 3'b101, 64'd0, 64'd0, 64'd0, 1'b1, 2, "pow 0^0 disabled"});
`endif

      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset busy %0d", s), {63'd0, busy_m}, 64'd0);
         check($sformatf("reset done %0d", s), {63'd0, done_m}, 64'd0);
         check($sformatf("reset out %0d", s), out_m, 64'd0);
         check($sformatf("reset err %0d", s), {63'd0, err_m}, 64'd0);
      end
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // A second request held through the MUL run must be dropped.
      start_op(1, 3'b010, 64'd200, 64'd3);
      check("mul8 busy after accept", {63'd0, busy_m}, 64'd1);
      @(negedge clk);
      op_c = 3'b000; a_c = 64'd1; b_c = 64'd1; start_c = 1'b1;
      repeat (3) @(posedge clk);
      #1 start_c = 1'b0;
      wait_done(c1);
      check("mul8 latency", 64'(c1 + 3), 64'd10);
      check("mul8 out", out_m, 64'd88);
      pulses = 0;
      repeat (15) begin
         @(posedge clk);
         #1 if (done_m) pulses++;
      end
      check("mul8 ignored start", 64'(pulses), 64'd0);

      // Back-to-back: REM issued in the DIV done cycle.
      start_op(0, 3'b011, 64'd1000, 64'd7);
      wait_done(c1);
      check("div64 latency", 64'(c1), 64'd66);
      check("div64 out", out_m, 64'd142);
      check("done cycle busy", {63'd0, busy_m}, 64'd0);
      op_c = 3'b100; start_c = 1'b1;
      @(posedge clk);
      #1 start_c = 1'b0;
      check("rem64 accepted", {63'd0, busy_m}, 64'd1);
      check("div64 out holds", out_m, 64'd142);
      wait_done(c2);
      check("rem64 latency", 64'(c2), 64'd66);
      check("rem64 out", out_m, 64'd6);
      check("rem64 err", {63'd0, err_m}, 64'd0);

      // Reset part way through a WIDTH=16 multiply.
      start_op(2, 3'b010, 64'd1000, 64'd3);
      pulses = 0;
      repeat (4) begin
         @(posedge clk);
         #1 if (done_m) pulses++;
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("mid reset busy", {63'd0, busy_m}, 64'd0);
      @(negedge clk) rst = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1 if (done_m) pulses++;
      end
      check("mid reset no done", 64'(pulses), 64'd0);
      check("mid reset out", out_m, 64'd0);
      run_vec('{2, 3'b000, 64'd1, 64'd1, 64'd2, 1'b0, 2, "add16 after reset"});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_calc_seq.md
# int_calc_seq

Parametrised, multi-cycle successor to the team's 64-bit combinational integer calculator. It replaces the single-cycle `*`, `/` and `%` operators with a shared shift-add multiplier and a restoring divider. The block adds a start/busy/done handshake, a divide-by-zero/illegal-op flag, and an optional iterative power operation. It sits between the operand/opcode decode stage and the result write-back in the arithmetic datapath.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width in bits; legal range 8–64.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request; sampled only when `busy`=0.
- `operation`, input, 3: opcode, sampled with `start`.
- `opa`, input, WIDTH: operand A, unsigned, sampled with `start`.
- `opb`, input, WIDTH: operand B, unsigned, sampled with `start`.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; `out`/`err` are valid from this cycle.
- `out`, output, WIDTH: result register; holds its value until the next `done`.
- `err`, output, 1: set with `done` on divide-by-zero or illegal opcode; otherwise cleared with `done`.

## Operation
- Opcodes:
  - 000: A+B.
  - 001: A−B.
  - 010: A×B, low WIDTH bits.
  - 011: A/B.
  - 100: A%B.
  - 101: A^B (only with the macro; see Configuration).
  - 110, 111: illegal.
- All arithmetic is unsigned and modulo 2^WIDTH. Carry, borrow and overflow are discarded.
- FSM states: IDLE, ALU, MUL, DIV, POW_MUL, POW_SQR, DONE.
  - IDLE: `start`=1 latches operands and opcode, sets `busy`. Next state is ALU (add, sub, illegal, div-by-zero, pow with B=0), MUL, DIV, or POW_MUL.
  - ALU: computes the result in one cycle → DONE.
  - MUL: one partial product per cycle, LSB-first over B. After WIDTH cycles → DONE.
  - DIV: one restoring quotient bit per cycle, MSB-first. After WIDTH cycles → DONE. Quotient and remainder come from the same pass.
  - POW: right-to-left square-and-multiply, reusing the MUL datapath (WIDTH cycles per multiply).
    - POW_MUL: if the current exponent bit is 1, acc ← acc×base; if the bit is 0, skip in 0 cycles.
    - POW_SQR: base ← base×base, then shift the exponent right.
    - The operation ends when the remaining exponent is 0.
  - DONE: writes `out`/`err`, pulses `done`, clears `busy` → IDLE.
- Divide by zero (B=0, op 011/100):
  - `out` = all-ones for 011, `out` = A for 100.
  - `err`=1; ALU-path latency.
- Illegal opcode: `out`=0, `err`=1, ALU-path latency.
- `start` while `busy`=1 is ignored. No queuing, and latched operands are unaffected.
- `rst` at any time: aborts any operation, returns to IDLE, no `done` is produced. Reset values: `busy`=0, `done`=0, `out`=0, `err`=0.

## Timing
- Let edge k be the edge where `start` is accepted. `busy`=1 after edge k.
- Latency from edge k to the `done` pulse:
  - ALU path: `done`=1 after edge k+2.
  - MUL, DIV, REM: `done`=1 after edge k+WIDTH+2.
  - POW: `done`=1 after edge k+2+WIDTH×(popcount(B)+bitlen(B)).
    - bitlen(B) is the index of the highest set bit of B, plus 1.
    - The final square is not skipped.
- `busy` drops in the same cycle that `done` rises. A `start` in the `done` cycle is accepted, giving back-to-back throughput with no bubble.
- `out` changes only on the edge that raises `done`.

## Configuration
- `INT_CALC_POW_EN` defined: opcode 101 performs A^B modulo 2^WIDTH. A^0 = 1, including 0^0 = 1, with ALU-path latency and `err`=0.
- Not defined: the POW states are not synthesised, and opcode 101 is treated as illegal (`out`=0, `err`=1, ALU-path latency).

## Test plan
- Reset/idle check (WIDTH=64): assert `rst` for 2 cycles → `busy`=0, `done`=0, `out`=0, `err`=0.
- Add with wrap (WIDTH=64): ADD with A=2^64−1, B=2 → `out`=1, `err`=0, `done` after edge k+2. Then SUB with A=3, B=5 → `out`=2^64−2.
- Multiply (WIDTH=8): MUL with A=200, B=3 → `out`=88 (600 mod 256), `done` after edge k+10. A `start` issued while `busy` is ignored.
- Divide and remainder (WIDTH=64):
  - DIV 1000/7 → 142.
  - REM 1000%7 → 6.
  - DIV with B=0 → all-ones and `err`=1 after edge k+2.
  - REM with B=0 → 1000.
  - The second `start` is issued in the first operation's `done` cycle and is accepted.
- Reset mid-operation (WIDTH=16): assert `rst` 5 cycles into a MUL → no `done`; the next ADD 1+1 → 2 with nominal latency.
- Power and illegal opcodes (WIDTH=8):
  - With `INT_CALC_POW_EN`: 3^5 → 243 (`done` after edge k+42); 2^9 → 0; 0^0 → 1.
  - Without the macro: opcode 101 → `out`=0, `err`=1.
  - Opcode 111 → `err`=1 in both builds.
